io_reg_f2a_tx_link: RTL

//  Upstream feeder for the IO_REG F2A path: buffers fabric words and drives them onto the OQI lanes of IO_REG.
//  - Valid/ready interface on the fabric side.
//  - Toggle handshake toward the ASSP: the ack echo returns on one A2F lane (an IQZ bit).
//  - Timeout detection halts the link; software clears it to recover.

---
 rtl/io_reg_pkg.sv | 19 +
 rtl/io_reg_sync_fifo.sv | 56 +++++
 rtl/io_reg_f2a_tx_link.sv | 125 ++++++++++++
 3 files changed

// File: rtl/io_reg_pkg.sv
// Shared types and lane-index helpers for the IO_REG F2A transmit link.
// The OQI lane layout is {toggle, last, data[DATA_W-1:0]}.
package io_reg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        HALT     = 2'd2
    } link_state_e;

    function automatic int lane_last(input int data_w);
        return data_w;
    endfunction

    function automatic int lane_tog(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/io_reg_sync_fifo.sv
// Single-clock FIFO with occupancy count and a synchronous flush.
// Head word is presented combinationally on rd_data.
module io_reg_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                           IQC,
    input  logic                           QRT,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               wr_data,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    // NOTE: the storage array carries no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge IQC) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state is assigned with <= only so every flop samples pre-edge values.
    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign level   = count;

endmodule

// File: rtl/io_reg_f2a_tx_link.sv
// Fabric-to-ASSP feeder: queues valid/ready words and sends them on the OQI lanes
// with a toggle handshake; a missing echo halts the link until software clears it.
module io_reg_f2a_tx_link
    import io_reg_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       IQC,
    input  logic                       QRT,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_last,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [DATA_W+1:0]          OQI_o,
    input  logic                       ack_i,
    input  logic                       err_clr,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int LANE_LAST = lane_last(DATA_W);
    localparam int LANE_TOG  = lane_tog(DATA_W);
    localparam int LVL_W     = $clog2(DEPTH + 1);
    localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    link_state_e      state;
    link_state_e      state_nxt;
    logic             tog;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W+1:0] oqi_q;
    logic             err_q;
    logic [DATA_W:0]  head;
    logic             push;
    logic             pop;
    logic             flush;
    logic             cnt_inc;
    logic             to_hit;

    assign s_ready = (level < LVL_W'(DEPTH)) && (state != HALT);
    assign push    = s_valid && s_ready;

    io_reg_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .IQC     (IQC),
        .QRT     (QRT),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data ({s_last, s_data}),
        .rd_data (head),
        .level   (level)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        flush     = 1'b0;
        cnt_inc   = 1'b0;
        to_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_i == tog) begin
                    state_nxt = IDLE;
                end else if (TIMEOUT != 0) begin
                    if (cnt == CNT_LAST) begin
                        to_hit    = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            HALT: begin
                if (err_clr) begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            state <= IDLE;
            tog   <= 1'b0;
            cnt   <= '0;
            oqi_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                oqi_q[LANE_TOG]    <= ~tog;
                oqi_q[LANE_LAST:0] <= head;
                tog                <= ~tog;
                cnt                <= '0;
            end
            if (cnt_inc) cnt <= cnt + 1'b1;
            if (to_hit)  err_q <= 1'b1;
            // Re-sync to whatever the ASSP currently echoes so the next send is a real edge.
            if (flush) begin
                tog   <= ack_i;
                err_q <= 1'b0;
            end
        end
    end

    assign OQI_o       = oqi_q;
    assign timeout_err = err_q;
    assign busy        = (level != '0) || (state != IDLE);

endmodule
